m_wbuart_tx: RTL

- Wishbone slave UART transmitter. It sits directly downstream of m_midgetv_core on the same wishbone bus as the wishbone register peripheral.
- The integrating top gates STB_I from an address decode of ADR_O. This block decodes only ADR_I[2] internally.
- Bytes written by software are buffered in a small FIFO, then serialised 8N1 on TXD.
- It is the console/debug output path for hardware and simulation builds.

---
 rtl/m_wbuart_tx_pkg.sv | 36 +++
 rtl/m_wbuart_fifo.sv | 70 +++++++
 rtl/m_wbuart_tx.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/m_wbuart_tx_pkg.sv
// Shared constants for the wishbone UART transmitter: register offsets,
// status bit positions, transmitter state encodings and the status word packer.
package m_wbuart_tx_pkg;

  localparam logic REG_DATA   = 1'b0;
  localparam logic REG_STATUS = 1'b1;

  localparam int STAT_EMPTY     = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_BUSY      = 2;
  localparam int STAT_OVF       = 3;
  localparam int STAT_COUNT_LSB = 8;

  localparam logic [1:0] TX_IDLE  = 2'b00;
  localparam logic [1:0] TX_START = 2'b01;
  localparam logic [1:0] TX_DATA  = 2'b10;
  localparam logic [1:0] TX_STOP  = 2'b11;

  function automatic logic [31:0] pack_status(
    input logic       empty,
    input logic       full,
    input logic       busy,
    input logic       ovf,
    input logic [4:0] count
  );
    logic [31:0] word;
    word                          = 32'h0000_0000;
    word[STAT_EMPTY]              = empty;
    word[STAT_FULL]               = full;
    word[STAT_BUSY]               = busy;
    word[STAT_OVF]                = ovf;
    word[STAT_COUNT_LSB +: 5]     = count;
    return word;
  endfunction

endpackage

// File: rtl/m_wbuart_fifo.sv
// Small synchronous circular-buffer FIFO with occupancy count.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module m_wbuart_fifo #(
  parameter int WIDTH        = 8,
  parameter int FIFOADRWIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      din,
  output logic [WIDTH-1:0]      dout,
  output logic                  empty,
  output logic                  full,
  output logic [FIFOADRWIDTH:0] count
);

  localparam int DEPTH = 1 << FIFOADRWIDTH;
  localparam logic [FIFOADRWIDTH:0]   DEPTH_C = (FIFOADRWIDTH+1)'(DEPTH);
  localparam logic [FIFOADRWIDTH:0]   CNT_ZERO = (FIFOADRWIDTH+1)'(1'b0);
  localparam logic [FIFOADRWIDTH:0]   CNT_ONE = (FIFOADRWIDTH+1)'(1'b1);
  localparam logic [FIFOADRWIDTH-1:0] PTR_ONE = (FIFOADRWIDTH)'(1'b1);

  logic [WIDTH-1:0]        mem_r [DEPTH];
  logic [FIFOADRWIDTH-1:0] rd_ptr_r;
  logic [FIFOADRWIDTH-1:0] wr_ptr_r;
  logic [FIFOADRWIDTH:0]   count_r;
  logic                    do_push_s;
  logic                    do_pop_s;

  // Qualify requests against the current occupancy
  always_comb begin
    empty     = (count_r == CNT_ZERO);
    full      = (count_r == DEPTH_C);
    do_pop_s  = pop & ~empty;
    do_push_s = push & (~full | do_pop_s);
  end

  // Storage array, written at the write pointer
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers and occupancy count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      if (do_push_s && !do_pop_s) begin
        count_r <= count_r + CNT_ONE;
      end else if (do_pop_s && !do_push_s) begin
        count_r <= count_r - CNT_ONE;
      end
    end
  end

  assign dout  = mem_r[rd_ptr_r];
  assign count = count_r;

endmodule

// File: rtl/m_wbuart_tx.sv
// Wishbone slave UART transmitter: buffers written bytes in a FIFO and
// serialises them 8N1 on TXD, with a status register for software polling.
module m_wbuart_tx
  import m_wbuart_tx_pkg::*;
#(
  parameter int FIFOADRWIDTH = 2,
  parameter int DIVISOR      = 104
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic        STB_I,
  input  logic        WE_I,
  input  logic        ADR_I,
  input  logic [3:0]  SEL_I,
  input  logic [31:0] DAT_I,
  output logic        ACK_O,
  output logic [31:0] DAT_O,
  output logic        TXD
);

  localparam logic [15:0] BAUD_RELOAD = 16'(DIVISOR - 1);
  localparam logic [15:0] BAUD_ZERO   = 16'h0000;
  localparam logic [15:0] BAUD_ONE    = 16'h0001;

  logic                  ack_r;
  logic [31:0]           dat_r;
  logic                  txd_r;
  logic                  ovf_r;
  logic [1:0]            state_r;
  logic [15:0]           baud_r;
  logic [7:0]            shift_r;
  logic [2:0]            bit_idx_r;

  logic                  access_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  stat_rd_s;
  logic                  ovf_evt_s;
  logic                  tick_s;
  logic                  busy_s;
  logic [7:0]            fifo_dout_s;
  logic                  fifo_empty_s;
  logic                  fifo_full_s;
  logic [FIFOADRWIDTH:0] fifo_count_s;
  logic                  unused_bits_s;

  assign unused_bits_s = ^{SEL_I[3:1], DAT_I[31:8]};

  // Bus decode and transmitter pop request
  always_comb begin
    access_s  = STB_I & ~ack_r;
    push_s    = access_s & WE_I & (ADR_I == REG_DATA) & SEL_I[0];
    stat_rd_s = access_s & ~WE_I & (ADR_I == REG_STATUS);
    tick_s    = (baud_r == BAUD_ZERO);
    busy_s    = (state_r != TX_IDLE);
    case (state_r)
      TX_IDLE: pop_s = ~fifo_empty_s;
      TX_STOP: pop_s = tick_s & ~fifo_empty_s;
      default: pop_s = 1'b0;
    endcase
    ovf_evt_s = push_s & fifo_full_s & ~pop_s;
  end

  m_wbuart_fifo #(
    .WIDTH       (8),
    .FIFOADRWIDTH(FIFOADRWIDTH)
  ) u_fifo (
    .clk  (CLK_I),
    .rst  (RST_I),
    .push (push_s),
    .pop  (pop_s),
    .din  (DAT_I[7:0]),
    .dout (fifo_dout_s),
    .empty(fifo_empty_s),
    .full (fifo_full_s),
    .count(fifo_count_s)
  );

  // Single-cycle acknowledge and read data, zero outside the ack cycle
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      ack_r <= 1'b0;
      dat_r <= 32'h0000_0000;
    end else begin
      ack_r <= access_s;
      if (stat_rd_s) begin
        dat_r <= pack_status(fifo_empty_s, fifo_full_s, busy_s, ovf_r, 5'(fifo_count_s));
      end else begin
        dat_r <= 32'h0000_0000;
      end
    end
  end

  // Sticky overflow: a new drop outranks the clear-on-read
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      ovf_r <= 1'b0;
    end else if (ovf_evt_s) begin
      ovf_r <= 1'b1;
    end else if (stat_rd_s) begin
      ovf_r <= 1'b0;
    end
  end

  // Serialiser; txd_r is loaded with the level of the upcoming cycle
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state_r   <= TX_IDLE;
      baud_r    <= BAUD_ZERO;
      shift_r   <= 8'h00;
      bit_idx_r <= 3'd0;
      txd_r     <= 1'b1;
    end else begin
      case (state_r)
        TX_IDLE: begin
          txd_r <= ~pop_s;
          if (pop_s) begin
            shift_r <= fifo_dout_s;
            baud_r  <= BAUD_RELOAD;
            state_r <= TX_START;
          end
        end
        TX_START: begin
          if (tick_s) begin
            baud_r    <= BAUD_RELOAD;
            bit_idx_r <= 3'd0;
            txd_r     <= shift_r[0];
            state_r   <= TX_DATA;
          end else begin
            baud_r <= baud_r - BAUD_ONE;
          end
        end
        TX_DATA: begin
          if (tick_s) begin
            baud_r    <= BAUD_RELOAD;
            shift_r   <= {1'b0, shift_r[7:1]};
            bit_idx_r <= bit_idx_r + 3'd1;
            if (bit_idx_r == 3'd7) begin
              txd_r   <= 1'b1;
              state_r <= TX_STOP;
            end else begin
              txd_r <= shift_r[1];
            end
          end else begin
            baud_r <= baud_r - BAUD_ONE;
          end
        end
        TX_STOP: begin
          if (tick_s) begin
            if (pop_s) begin
              shift_r <= fifo_dout_s;
              baud_r  <= BAUD_RELOAD;
              txd_r   <= 1'b0;
              state_r <= TX_START;
            end else begin
              txd_r   <= 1'b1;
              state_r <= TX_IDLE;
            end
          end else begin
            baud_r <= baud_r - BAUD_ONE;
          end
        end
        default: begin
          txd_r   <= 1'b1;
          state_r <= TX_IDLE;
        end
      endcase
    end
  end

  assign ACK_O = ack_r;
  assign DAT_O = dat_r;
  assign TXD   = txd_r;

endmodule
